// File: rtl/srl_delay_line.sv
// Multi-channel runtime-addressable shift-register delay line with per-channel
// clock enable, fill tracking and optional registered output.
module srl_delay_line #(
    parameter int               CHANNELS = 4,
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 32,
    parameter int               AW       = $clog2(DEPTH),
    parameter bit               NEG_CLK  = 1'b0,
    parameter logic [WIDTH-1:0] INIT_PAT = '0,
    parameter bit               OUT_REG  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS-1:0]          ce,
    input  logic [CHANNELS-1:0]          flush,
    input  logic [CHANNELS*WIDTH-1:0]    din,
    input  logic [CHANNELS*AW-1:0]       addr,
    output logic [CHANNELS*WIDTH-1:0]    dout,
    output logic [CHANNELS-1:0]          dout_valid
);

    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    // Every flop in the block shares this edge, so NEG_CLK flips them all together.
    logic aclk;
    assign aclk = NEG_CLK ? ~clk : clk;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        // No reset on the chain so it can map onto SRL primitives.
        logic [WIDTH-1:0] sr [DEPTH] = '{default: INIT_PAT};
        logic [CW-1:0]    cnt;
        logic [AW-1:0]    sel_p0;
        logic [WIDTH-1:0] tap_p0;
        logic             vld_p0;

        always_ff @(posedge aclk) begin
            if (ce[c]) begin
                sr[0] <= din[c*WIDTH +: WIDTH];
                for (int k = 1; k < DEPTH; k++) begin
                    sr[k] <= sr[k-1];
                end
            end
        end

        // Fill count: a flush on an enabled edge still counts that edge's sample.
        always_ff @(posedge aclk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (flush[c]) begin
                cnt <= ce[c] ? CW'(1) : '0;
            end else if (ce[c] && (int'(cnt) < DEPTH)) begin
                cnt <= cnt + CW'(1);
            end
        end

        // Stage p0: tap select with clamp to the last stage
        assign sel_p0 = (int'(addr[c*AW +: AW]) > DEPTH - 1) ? LAST : addr[c*AW +: AW];
        assign tap_p0 = sr[sel_p0];
        assign vld_p0 = int'(cnt) > int'(sel_p0);

        if (OUT_REG) begin : g_oreg
            logic [WIDTH-1:0] dout_p1;
            logic             vld_p1;

            // Stage p1: output register, captured every edge regardless of ce
            always_ff @(posedge aclk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_p1 <= '0;
                    vld_p1  <= 1'b0;
                end else begin
                    dout_p1 <= tap_p0;
                    vld_p1  <= vld_p0;
                end
            end

            assign dout[c*WIDTH +: WIDTH] = dout_p1;
            assign dout_valid[c]          = vld_p1;
        end else begin : g_ocomb
            assign dout[c*WIDTH +: WIDTH] = tap_p0;
            assign dout_valid[c]          = vld_p0;
        end
    end

endmodule

// File: tb/tb_srl_delay_line.sv
// Bench for srl_delay_line: a rising-edge registered 4-channel instance and a
// falling-edge combinational 2-channel instance, both against a sample-history model.
module tb_srl_delay_line;

    localparam int         CH    = 4;
    localparam int         W     = 8;
    localparam int         D     = 32;
    localparam int         AW    = 5;
    localparam int         CHB   = 2;
    localparam int         DB    = 20;
    localparam int         AWB   = 5;
    localparam logic [7:0] INITB = 8'hA5;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_nb;

    logic [CH-1:0]      ce;
    logic [CH-1:0]      flush;
    logic [CH*W-1:0]    din;
    logic [CH*AW-1:0]   addr;
    logic [CH*W-1:0]    dout;
    logic [CH-1:0]      dout_valid;

    logic [CHB-1:0]     ceb;
    logic [CHB-1:0]     flushb;
    logic [CHB*W-1:0]   dinb;
    logic [CHB*AWB-1:0] addrb;
    logic [CHB*W-1:0]   doutb;
    logic [CHB-1:0]     doutb_valid;

    int checks = 0;
    int errors = 0;

    // Model: every sample ever shifted in, plus the history index at the last reset/flush.
    logic [7:0] smp_a [CH][$];
    int         mark_a [CH];
    logic [7:0] exp_d [CH];
    logic       exp_v [CH];
    logic [7:0] smp_b [CHB][$];
    int         mark_b [CHB];

    always #5 clk = ~clk;

    srl_delay_line #(
        .CHANNELS(CH), .WIDTH(W), .DEPTH(D), .AW(AW),
        .NEG_CLK(1'b0), .INIT_PAT(8'h00), .OUT_REG(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush), .din(din),
        .addr(addr), .dout(dout), .dout_valid(dout_valid)
    );

    srl_delay_line #(
        .CHANNELS(CHB), .WIDTH(W), .DEPTH(DB), .AW(AWB),
        .NEG_CLK(1'b1), .INIT_PAT(INITB), .OUT_REG(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_nb), .ce(ceb), .flush(flushb), .din(dinb),
        .addr(addrb), .dout(doutb), .dout_valid(doutb_valid)
    );

    function automatic logic [7:0] tap_a(int c);
        int k = int'(addr[c*AW +: AW]);
        int n = smp_a[c].size();
        if (n > k) return smp_a[c][n-1-k];
        return 8'h00;
    endfunction

    function automatic logic vld_a(int c);
        int k = int'(addr[c*AW +: AW]);
        return (smp_a[c].size() - mark_a[c]) > k;
    endfunction

    function automatic int clampb(int c);
        int k = int'(addrb[c*AWB +: AWB]);
        return (k > DB - 1) ? DB - 1 : k;
    endfunction

    function automatic logic [7:0] tap_b(int c);
        int k = clampb(c);
        int n = smp_b[c].size();
        if (n > k) return smp_b[c][n-1-k];
        return INITB;
    endfunction

    function automatic logic vld_b(int c);
        return (smp_b[c].size() - mark_b[c]) > clampb(c);
    endfunction

    task automatic tick();
        logic [7:0] pd [CH];
        logic       pv [CH];
        for (int c = 0; c < CH; c++) begin
            pd[c] = tap_a(c);
            pv[c] = vld_a(c);
        end
        @(posedge clk);
        for (int c = 0; c < CH; c++) begin
            exp_d[c] = pd[c];
            exp_v[c] = pv[c];
            if (flush[c]) mark_a[c] = smp_a[c].size();
            if (ce[c]) smp_a[c].push_back(din[c*W +: W]);
        end
        #1;
    endtask

    task automatic tick_b();
        @(negedge clk);
        for (int c = 0; c < CHB; c++) begin
            if (flushb[c]) mark_b[c] = smp_b[c].size();
            if (ceb[c]) smp_b[c].push_back(dinb[c*W +: W]);
        end
        #1;
    endtask

    task automatic do_reset_a();
        rst_n = 1'b0;
        for (int c = 0; c < CH; c++) begin
            mark_a[c] = smp_a[c].size();
            exp_d[c]  = 8'h00;
            exp_v[c]  = 1'b0;
        end
        #2;
        rst_n = 1'b1;
    endtask

    task automatic rand_chan(int c);
        ce[c]            = ($urandom_range(0, 3) != 0);
        flush[c]         = ($urandom_range(0, 15) == 0);
        din[c*W +: W]    = 8'($urandom);
        addr[c*AW +: AW] = 5'($urandom_range(0, 31));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_nb = 1'b0;
        ce = '0; flush = '0; din = '0; addr = '0;
        ceb = '0; flushb = '0; dinb = '0; addrb = '0;
        for (int c = 0; c < CH; c++) begin
            mark_a[c] = 0; exp_d[c] = 8'h00; exp_v[c] = 1'b0;
        end
        for (int c = 0; c < CHB; c++) mark_b[c] = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dout !== '0 || dout_valid !== '0) begin
                errors++;
                $display("FAIL reset_a pass%0d: dout=%h valid=%b, expected all zero", i, dout, dout_valid);
            end
            checks++;
            if (doutb !== {INITB, INITB} || doutb_valid !== '0) begin
                errors++;
                $display("FAIL reset_b pass%0d: dout=%h valid=%b, expected dout=a5a5 valid=00", i, doutb, doutb_valid);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1; rst_nb = 1'b1;
    endtask

    task automatic test_addr0();
        do_reset_a();
        addr[0 +: AW] = '0; ce[0] = 1'b1; flush[0] = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            din[0 +: W] = 8'(e);
            for (int c = 1; c < CH; c++) rand_chan(c);
            tick();
            checks++;
            if (dout_valid[0] !== (e >= 2) || (e >= 2 && dout[0 +: W] !== 8'(e - 1))) begin
                errors++;
                $display("FAIL addr0 e=%0d: dout=%h valid=%b, expected dout=%h valid=%b",
                         e, dout[0 +: W], dout_valid[0], 8'(e - 1), e >= 2);
            end
            for (int c = 0; c < CH; c++) begin
                checks++;
                if (dout[c*W +: W] !== exp_d[c] || dout_valid[c] !== exp_v[c]) begin
                    errors++;
                    $display("FAIL addr0_model e=%0d ch%0d: dout=%h valid=%b, expected dout=%h valid=%b",
                             e, c, dout[c*W +: W], dout_valid[c], exp_d[c], exp_v[c]);
                end
            end
        end
    endtask

    task automatic test_addr_max();
        do_reset_a();
        addr[AW +: AW] = 5'd31; ce[1] = 1'b1; flush[1] = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            din[W +: W] = 8'(e);
            rand_chan(0); rand_chan(2); rand_chan(3);
            tick();
            checks++;
            if (dout_valid[1] !== (e >= 33) || (e >= 33 && dout[W +: W] !== 8'(e - 32))) begin
                errors++;
                $display("FAIL addr_max e=%0d: dout=%h valid=%b, expected dout=%h valid=%b",
                         e, dout[W +: W], dout_valid[1], 8'(e - 32), e >= 33);
            end
            for (int c = 0; c < CH; c++) begin
                checks++;
                if (dout[c*W +: W] !== exp_d[c] || dout_valid[c] !== exp_v[c]) begin
                    errors++;
                    $display("FAIL addr_max_model e=%0d ch%0d: dout=%h valid=%b, expected dout=%h valid=%b",
                             e, c, dout[c*W +: W], dout_valid[c], exp_d[c], exp_v[c]);
                end
            end
        end
    endtask

    task automatic test_ce_gaps();
        int   en_before = 0;
        logic wv;
        do_reset_a();
        addr[2*AW +: AW] = 5'd3; flush[2] = 1'b0;
        for (int e = 0; e < 24; e++) begin
            ce[2] = (e % 2 == 0);
            din[2*W +: W] = 8'($urandom);
            rand_chan(0); rand_chan(1); rand_chan(3);
            wv = (en_before >= 4);
            if (ce[2]) en_before++;
            tick();
            checks++;
            if (dout_valid[2] !== wv) begin
                errors++;
                $display("FAIL ce_gaps e=%0d: valid=%b, expected valid=%b", e, dout_valid[2], wv);
            end
            for (int c = 0; c < CH; c++) begin
                checks++;
                if (dout[c*W +: W] !== exp_d[c] || dout_valid[c] !== exp_v[c]) begin
                    errors++;
                    $display("FAIL ce_gaps_model e=%0d ch%0d: dout=%h valid=%b, expected dout=%h valid=%b",
                             e, c, dout[c*W +: W], dout_valid[c], exp_d[c], exp_v[c]);
                end
            end
        end
    endtask

    task automatic test_addr_change();
        logic       wv;
        logic [7:0] wd;
        do_reset_a();
        ce[3] = 1'b1; flush[3] = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            addr[3*AW +: AW] = (e <= 7) ? 5'd5 : 5'd10;
            din[3*W +: W] = 8'(e);
            rand_chan(0); rand_chan(1); rand_chan(2);
            tick();
            if (e <= 7) begin
                wv = (e == 7); wd = 8'(e - 6);
            end else begin
                wv = (e >= 12); wd = 8'(e - 11);
            end
            checks++;
            if (dout_valid[3] !== wv || (wv && dout[3*W +: W] !== wd)) begin
                errors++;
                $display("FAIL addr_change e=%0d: dout=%h valid=%b, expected dout=%h valid=%b",
                         e, dout[3*W +: W], dout_valid[3], wd, wv);
            end
            for (int c = 0; c < CH; c++) begin
                checks++;
                if (dout[c*W +: W] !== exp_d[c] || dout_valid[c] !== exp_v[c]) begin
                    errors++;
                    $display("FAIL addr_change_model e=%0d ch%0d: dout=%h valid=%b, expected dout=%h valid=%b",
                             e, c, dout[c*W +: W], dout_valid[c], exp_d[c], exp_v[c]);
                end
            end
        end
    endtask

    task automatic test_async_reset_flush();
        ce = '1; flush = '0;
        for (int c = 0; c < CH; c++) addr[c*AW +: AW] = 5'd2;
        for (int e = 0; e < 6; e++) begin
            din = CH*W'($urandom);
            tick();
        end
        checks++;
        if (dout_valid !== '1) begin
            errors++;
            $display("FAIL prefill: valid=%b, expected 1111", dout_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== '0 || dout_valid !== '0) begin
            errors++;
            $display("FAIL async_reset: dout=%h valid=%b, expected all zero", dout, dout_valid);
        end
        for (int c = 0; c < CH; c++) begin
            mark_a[c] = smp_a[c].size(); exp_d[c] = 8'h00; exp_v[c] = 1'b0;
        end
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            din = CH*W'($urandom);
            flush = '0; ce = '1;
            if (e == 5) begin
                flush = 4'b0110;
                ce[2] = 1'b0;
            end
            tick();
            if (e <= 4) begin
                checks++;
                if (dout_valid[0] !== (e >= 4)) begin
                    errors++;
                    $display("FAIL post_reset e=%0d: valid=%b, expected %b", e, dout_valid[0], e >= 4);
                end
            end
            if (e == 6) begin
                checks++;
                if (dout_valid !== 4'b1001) begin
                    errors++;
                    $display("FAIL flush_isolation: valid=%b, expected 1001", dout_valid);
                end
            end
            for (int c = 0; c < CH; c++) begin
                checks++;
                if (dout[c*W +: W] !== exp_d[c] || dout_valid[c] !== exp_v[c]) begin
                    errors++;
                    $display("FAIL reset_flush_model e=%0d ch%0d: dout=%h valid=%b, expected dout=%h valid=%b",
                             e, c, dout[c*W +: W], dout_valid[c], exp_d[c], exp_v[c]);
                end
            end
        end
        ce = '0; flush = '0;
    endtask

    task automatic test_negclk_comb();
        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < CHB; c++) begin
                ceb[c]             = ($urandom_range(0, 3) != 0);
                flushb[c]          = ($urandom_range(0, 19) == 0);
                dinb[c*W +: W]     = 8'($urandom);
                addrb[c*AWB +: AWB] = 5'($urandom_range(0, 31));
            end
            #1;
            for (int c = 0; c < CHB; c++) begin
                checks++;
                if (doutb[c*W +: W] !== tap_b(c) || doutb_valid[c] !== vld_b(c)) begin
                    errors++;
                    $display("FAIL negclk_hold it=%0d ch%0d: dout=%h valid=%b, expected dout=%h valid=%b",
                             it, c, doutb[c*W +: W], doutb_valid[c], tap_b(c), vld_b(c));
                end
            end
            tick_b();
            for (int c = 0; c < CHB; c++) begin
                checks++;
                if (doutb[c*W +: W] !== tap_b(c) || doutb_valid[c] !== vld_b(c)) begin
                    errors++;
                    $display("FAIL negclk_fall it=%0d ch%0d: dout=%h valid=%b, expected dout=%h valid=%b",
                             it, c, doutb[c*W +: W], doutb_valid[c], tap_b(c), vld_b(c));
                end
            end
            @(posedge clk); #1;
            for (int c = 0; c < CHB; c++) begin
                checks++;
                if (doutb[c*W +: W] !== tap_b(c) || doutb_valid[c] !== vld_b(c)) begin
                    errors++;
                    $display("FAIL negclk_rise it=%0d ch%0d: dout=%h valid=%b, expected dout=%h valid=%b",
                             it, c, doutb[c*W +: W], doutb_valid[c], tap_b(c), vld_b(c));
                end
            end
            if (it == 25) begin
                rst_nb = 1'b0;
                for (int c = 0; c < CHB; c++) mark_b[c] = smp_b[c].size();
                #1;
                for (int c = 0; c < CHB; c++) begin
                    checks++;
                    if (doutb[c*W +: W] !== tap_b(c) || doutb_valid[c] !== 1'b0) begin
                        errors++;
                        $display("FAIL negclk_reset ch%0d: dout=%h valid=%b, expected dout=%h valid=0",
                                 c, doutb[c*W +: W], doutb_valid[c], tap_b(c));
                    end
                end
                rst_nb = 1'b1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_addr0();
        test_addr_max();
        test_ce_gaps();
        test_addr_change();
        test_async_reset_flush();
        test_negclk_comb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
